// File: rtl/store_buffer.sv
// Pending-store FIFO that drains one single-beat AXI write at a time, with a load hazard check.
// Define STORE_BUF_HAZARD_CMP_EN for per-entry address compare; otherwise ld_conflict = ~empty.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_valid,
   input  logic [31:0] push_addr,
   input  logic [31:0] push_data,
   input  logic [3:0]  push_strb,
   output logic        full,
   output logic        empty,
   output logic [4:0]  count,
   input  logic [31:0] ld_addr,
   output logic        ld_conflict,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   input  logic        bvalid,
   output logic        bready
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

   state_t        state_reg, state_next;
   logic          aw_done_reg, aw_done_next;
   logic          w_done_reg, w_done_next;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [4:0]    count_reg;

   // Word address only: byte offset is carried by the strobe.
   logic [29:0]   addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [3:0]    strb_mem [DEPTH];

   logic          push_accept;
   logic          retire;

   assign full        = (count_reg == 5'(DEPTH));
   assign empty       = (count_reg == 5'd0);
   assign count       = count_reg;
   assign push_accept = push_valid && (push_strb != 4'b0000) && !full;
   assign retire      = (state_reg == WAIT_B) && bvalid;

   always_ff @(posedge clk) begin
      if (push_accept) begin
         addr_mem[wr_ptr_reg] <= push_addr[31:2];
         data_mem[wr_ptr_reg] <= push_data;
         strb_mem[wr_ptr_reg] <= push_strb;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         state_reg   <= IDLE;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         aw_done_reg <= aw_done_next;
         w_done_reg  <= w_done_next;
         if (push_accept) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (retire) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (push_accept && !retire) begin
            count_reg <= count_reg + 5'd1;
         end else if (retire && !push_accept) begin
            count_reg <= count_reg - 5'd1;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      aw_done_next = aw_done_reg;
      w_done_next  = w_done_reg;
      case (state_reg)
         IDLE: begin
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            if (!empty) begin
               state_next = SEND;
            end
         end
         SEND: begin
            // AW and W complete independently; leave only when both are done.
            if (awvalid && awready) begin
               aw_done_next = 1'b1;
            end
            if (wvalid && wready) begin
               w_done_next = 1'b1;
            end
            if (aw_done_next && w_done_next) begin
               state_next = WAIT_B;
            end
         end
         WAIT_B: begin
            if (bvalid) begin
               state_next   = IDLE;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign awvalid = (state_reg == SEND) && !aw_done_reg;
   assign wvalid  = (state_reg == SEND) && !w_done_reg;
   assign bready  = (state_reg == WAIT_B);
   assign awaddr  = {addr_mem[rd_ptr_reg], 2'b00};
   assign awlen   = 8'd0;
   assign awsize  = 3'b010;
   assign wdata   = data_mem[rd_ptr_reg];
   assign wstrb   = strb_mem[rd_ptr_reg];
   assign wlast   = 1'b1;

`ifdef STORE_BUF_HAZARD_CMP_EN
   logic [DEPTH-1:0] hit;
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
         logic [PW-1:0] offset;
         // An entry is live when its distance from the head is below count.
         assign offset  = PW'(gi) - rd_ptr_reg;
         assign hit[gi] = ({{(5-PW){1'b0}}, offset} < count_reg) &&
                          (addr_mem[gi] == ld_addr[31:2]);
      end
   endgenerate
   assign ld_conflict = |hit;
   logic unused_bits;
   assign unused_bits = ^{push_addr[1:0], ld_addr[1:0]};
`else
   assign ld_conflict = !empty;
   logic unused_bits;
   assign unused_bits = ^{push_addr[1:0], ld_addr};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid;
   logic [31:0] push_addr;
   logic [31:0] push_data;
   logic [3:0]  push_strb;
   logic        full, empty;
   logic [4:0]  count;
   logic [31:0] ld_addr;
   logic        ld_conflict;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data), .push_strb(push_strb),
      .full(full), .empty(empty), .count(count),
      .ld_addr(ld_addr), .ld_conflict(ld_conflict),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } store_t;

   store_t q[$];
   int     checks = 0;
   int     failures = 0;
   int     aw_cnt = 0;
   logic   aw_done_tb = 1'b0, w_done_tb = 1'b0;
   logic   aw_hs, w_hs, b_hs;

   function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endfunction

   function automatic logic exp_conflict();
`ifdef STORE_BUF_HAZARD_CMP_EN
      foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) return 1'b1;
      return 1'b0;
`else
      return q.size() != 0;
`endif
   endfunction

   function automatic void monitor();
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("ld_conflict", 32'(ld_conflict), 32'(exp_conflict()));
      chk("bready", 32'(bready), 32'(aw_done_tb && w_done_tb));
      if (q.size() == 0) begin
         chk("awvalid_idle", 32'(awvalid), 32'd0);
         chk("wvalid_idle", 32'(wvalid), 32'd0);
      end else begin
         if (awvalid) begin
            chk("aw_repeat", 32'(aw_done_tb), 32'd0);
            chk("awaddr", awaddr, {q[0].addr[31:2], 2'b00});
            chk("awlen", 32'(awlen), 32'd0);
            chk("awsize", 32'(awsize), 32'd2);
         end
         if (wvalid) begin
            chk("w_repeat", 32'(w_done_tb), 32'd0);
            chk("wdata", wdata, q[0].data);
            chk("wstrb", 32'(wstrb), 32'(q[0].strb));
            chk("wlast", 32'(wlast), 32'd1);
         end
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
   endfunction

   function automatic void update();
      int size0 = q.size();
      if (rst) return;
      if (b_hs) begin
         void'(q.pop_front());
         aw_done_tb = 1'b0;
         w_done_tb  = 1'b0;
      end
      if (aw_hs) begin
         aw_done_tb = 1'b1;
         aw_cnt++;
      end
      if (w_hs) w_done_tb = 1'b1;
      if (push_valid && push_strb != 4'b0 && size0 < DEPTH)
         q.push_back('{addr: push_addr, data: push_data, strb: push_strb});
   endfunction

   task automatic cyc();
      @(negedge clk);
      monitor();
      @(posedge clk);
      update();
      #1;
   endtask

   task automatic push(logic [31:0] a, logic [31:0] d, logic [3:0] s);
      push_valid = 1'b1; push_addr = a; push_data = d; push_strb = s;
      cyc();
      push_valid = 1'b0;
   endtask

   task automatic drain();
      push_valid = 1'b0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
      for (int i = 0; i < 200 && q.size() != 0; i++) cyc();
      bvalid = 1'b0;
      cyc();
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_empty", 32'(empty), 32'd1);
   endtask

   initial begin
      logic [3:0] strb_tab [8];
      int aw0;
      strb_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h0};
      rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0; push_strb = '0;
      ld_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_bready", 32'(bready), 32'd0);
      chk("rst_ldc", 32'(ld_conflict), 32'd0);
      rst = 1'b0;
      cyc();

      // Single store, two-cycle push-to-awvalid latency
      awready = 1'b1; wready = 1'b1;
      push(32'h8000_1002, 32'h00AB_0000, 4'b0100);
      chk("s_count1", 32'(count), 32'd1);
      chk("s_aw_lat1", 32'(awvalid), 32'd0);
      cyc();
      chk("s_awvalid", 32'(awvalid), 32'd1);
      chk("s_wvalid", 32'(wvalid), 32'd1);
      chk("s_awaddr", awaddr, 32'h8000_1000);
      chk("s_wdata", wdata, 32'h00AB_0000);
      chk("s_wstrb", 32'(wstrb), 32'h4);
      cyc();
      chk("s_bready", 32'(bready), 32'd1);
      chk("s_aw_drop", 32'(awvalid), 32'd0);
      bvalid = 1'b1;
      cyc();
      bvalid = 1'b0;
      chk("s_count0", 32'(count), 32'd0);
      chk("s_empty", 32'(empty), 32'd1);
      chk("s_bready0", 32'(bready), 32'd0);

      // Five back-to-back pushes into a stalled bus
      awready = 1'b0; wready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_valid = 1'b1; push_addr = 32'h100 + 32'(i * 4);
         push_data = 32'hD000 + 32'(i); push_strb = 4'hF;
         cyc();
         if (i == 3) chk("f_full4", 32'(full), 32'd1);
      end
      push_valid = 1'b0;
      chk("f_count", 32'(count), 32'd4);
      aw0 = aw_cnt;
      drain();
      chk("f_writes", 32'(aw_cnt - aw0), 32'd4);

      // AW accepted in SEND cycle 3, W in cycle 6
      push(32'h200, 32'h1234_5678, 4'h3);
      for (int i = 0; i < 10 && !awvalid; i++) cyc();
      chk("t_awvalid_start", 32'(awvalid), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         awready = (k == 3); wready = (k == 6); bvalid = (k == 8);
         chk($sformatf("t_awvalid_c%0d", k), 32'(awvalid), 32'(k <= 3));
         chk($sformatf("t_wvalid_c%0d", k), 32'(wvalid), 32'(k <= 6));
         chk($sformatf("t_bready_c%0d", k), 32'(bready), 32'(k >= 7));
         cyc();
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      chk("t_empty", 32'(empty), 32'd1);

      // Full buffer, push coincident with B handshake
      for (int i = 0; i < 4; i++) push(32'h300 + 32'(i * 4), 32'hE000 + 32'(i), 4'h1);
      awready = 1'b1; wready = 1'b1;
      for (int i = 0; i < 20 && !bready; i++) cyc();
      chk("c_bready", 32'(bready), 32'd1);
      awready = 1'b0; wready = 1'b0;
      chk("c_full", 32'(full), 32'd1);
      push_valid = 1'b1; push_addr = 32'h3F0; push_data = 32'hBAD; push_strb = 4'hF;
      bvalid = 1'b1;
      cyc();
      push_valid = 1'b0; bvalid = 1'b0;
      chk("c_count3", 32'(count), 32'd3);
      chk("c_notfull", 32'(full), 32'd0);
      drain();

      // Load hazard against a pending entry
      push(32'h1000, 32'hCAFE, 4'hF);
      ld_addr = 32'h1003; #1;
      chk("h_same_word", 32'(ld_conflict), 32'd1);
      ld_addr = 32'h1004; #1;
`ifdef STORE_BUF_HAZARD_CMP_EN
      chk("h_next_word", 32'(ld_conflict), 32'd0);
`else
      chk("h_next_word", 32'(ld_conflict), 32'd1);
`endif
      drain();

      // Reset during WAIT_B with two entries
      awready = 1'b1; wready = 1'b1;
      push(32'h400, 32'h1, 4'h1);
      push(32'h404, 32'h2, 4'h2);
      for (int i = 0; i < 20 && !bready; i++) cyc();
      chk("r_bready_pre", 32'(bready), 32'd1);
      rst = 1'b1; #1;
      chk("r_bready", 32'(bready), 32'd0);
      chk("r_count", 32'(count), 32'd0);
      chk("r_empty", 32'(empty), 32'd1);
      q.delete(); aw_done_tb = 1'b0; w_done_tb = 1'b0;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("r_no_aw", 32'(awvalid), 32'd0);
      end

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         push_valid = 1'($urandom_range(0, 1));
         push_addr  = 32'h2000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
         push_data  = $urandom;
         push_strb  = strb_tab[$urandom_range(0, 7)];
         awready    = ($urandom_range(0, 2) != 0);
         wready     = ($urandom_range(0, 2) != 0);
         bvalid     = ($urandom_range(0, 1) != 0);
         ld_addr    = 32'h2000 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
         cyc();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
